tpi_hs: RTL and testbench
=========================

# tpi_hs

Parametrised, fully synchronous successor to the 6523-style triple port interface used on the TCBM paddle. It provides three bidirectional ports of configurable width with data-direction registers, and adds a hardware DAV/ACK handshake engine on port A with status and interrupt. It sits behind the address decoder, which delivers a one-cycle chip-select strobe, and drives the TCBM data, status and handshake pins.

## Interface
Parameters:
- `WIDTH_A`, 8: port A width (1..8).
- `WIDTH_B`, 2: port B width (1..8), LSB-aligned on the data bus.
- `WIDTH_C`, 2: port C width (1..8), MSB-aligned on the data bus.
- `TIMEOUT`, 1023: handshake wait limit, in clock cycles (1..65535).

Ports:
- `clock` in 1: single system clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `cs` in 1: one-cycle access strobe from the decoder.
- `we` in 1: 1 = write, 0 = read; sampled with `cs`.
- `rs` in 3: register select.
- `din` in 8: CPU write data.
- `dout` out 8: CPU read data.
- `pa_in` / `pa_out` / `pa_oe`, in/out/out, `WIDTH_A` each: port A pin input, output latch, and output enable (= DDRA).
- `pb_in` / `pb_out` / `pb_oe`, `WIDTH_B` each: same for port B.
- `pc_in` / `pc_out` / `pc_oe`, `WIDTH_C` each: same for port C.
- `dav` out 1: data-available strobe to the drive.
- `ack` in 1: acknowledge from the drive; asynchronous.
- `irq` out 1: interrupt, active-high.

## Operation
Register map:
- `rs`=0: PA. 1: PB. 2: PC. 3: DDRA. 4: DDRB. 5: DDRC.
- `rs`=6: CR. bit0 `hs_en`, bit1 `irq_en`.
- `rs`=7: SR. bit0 `busy`, bit1 `done`, bit2 `tmo`, bit3 `ovr`. Read-only; a read clears bits 1–3.

Port behaviour:
- A port read returns `in` for bits whose DDR bit is 0, and the latch value for bits whose DDR bit is 1.
- Bus bits outside a port's width read 0, and writes to them are ignored.
- A DDR bit of 1 means output.

Handshake FSM, states IDLE, WAIT_HI, WAIT_LO:
- IDLE: a PA write with `hs_en`=1 updates the latch, sets `dav`=1 and `busy`=1, and moves to WAIT_HI.
- WAIT_HI: `ack_s`=1 → `dav`=0, go to WAIT_LO.
- WAIT_LO: `ack_s`=0 → go to IDLE with `busy`=0 and `done`=1.
- `ack_s` is `ack` after a 2-flop synchroniser.
- Any PA write while `busy` is dropped: the latch is unchanged and `ovr` is set.
- A PA write with `hs_en`=0 is a plain latch write; `dav` is not touched.
- Clearing `hs_en` mid-handshake aborts it: `dav`=0, go to IDLE, `busy`=0, no `done`.
- `irq` = `irq_en` & (`done` | `tmo`).
- A flag set and an SR read in the same cycle: the set wins, and the flag reads back 1 on the next read.

## Timing
Reset values:
- `dout`=0 and all latches and DDRs are 0, so all pins are inputs.
- CR=0 and SR=0, `dav`=0, `irq`=0, FSM in IDLE.
- The synchroniser flops reset to 0.

Latencies:
- Writes take effect at the rising edge that samples `cs`&`we`. Outputs reflect the change that cycle.
- Reads: `dout` is registered on the sampling edge and holds until the next read.
- `dav` rises on the same edge as the PA write.
- `ack`→`dav` fall takes 3 cycles: 2 synchroniser cycles plus 1 FSM cycle.
- `cs` with an undefined strobe width: each cycle with `cs`=1 is one access. The decoder guarantees single-cycle pulses.
- A reset mid-handshake forces IDLE and `dav`=0 on that edge.

## Configuration
- `TPI_HS_TIMEOUT_EN` defined:
  - A 16-bit counter clears on every state entry and runs in WAIT_HI and WAIT_LO.
  - When it reaches `TIMEOUT`: `dav`=0, `tmo`=1, `busy`=0, go to IDLE. `done` is not set.
- `TPI_HS_TIMEOUT_EN` undefined: no counter is built, the FSM waits indefinitely, and SR bit2 reads 0.

## Test plan
- Reset, then read all 8 registers → all 0x00, `dav`=0, `irq`=0, all `*_oe`=0.
- DDRA=0xF0, PA=0xA5, `pa_in`=0x3C → `pa_out`=0xA5, `pa_oe`=0xF0, PA read=0xAC.
- Defaults: write PB=0xFF and PC=0xFF with DDRs=0xFF, pins=0 → PB reads 0x03 and PC reads 0xC0.
- CR=0x03, write PA=0x55 → `dav`=1 that edge, SR=0x01.
  - Raise `ack` → `dav`=0 exactly 3 cycles later.
  - Drop `ack` → `irq`=1 3 cycles later. SR read=0x02, next SR read=0x00, `irq`=0.
- Timeout (with `TPI_HS_TIMEOUT_EN`, `TIMEOUT`=16): CR=0x03, PA write, `ack` held 0 → `dav`=0 after 16 cycles, SR read=0x04, `irq` was 1.
- Overrun while `busy`: write PA=0x77 → `pa_out` stays 0x55 and SR bit3=1. An SR read on the same cycle `done` sets returns bit1=0, the next read returns 1.

Source files
------------

// File: rtl/tpi_hs.sv
`default_nettype none
// ============================================================================
// Module   : tpi_hs
// Brief    : Triple port interface with a DAV/ACK handshake engine on port A.
//            Optional handshake timeout is built when TPI_HS_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tpi_hs #(
  parameter int WIDTH_A = 8,
  parameter int WIDTH_B = 2,
  parameter int WIDTH_C = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cs,
  input  logic               we,
  input  logic [2:0]         rs,
  input  logic [7:0]         din,
  output logic [7:0]         dout,
  input  logic [WIDTH_A-1:0] pa_in,
  output logic [WIDTH_A-1:0] pa_out,
  output logic [WIDTH_A-1:0] pa_oe,
  input  logic [WIDTH_B-1:0] pb_in,
  output logic [WIDTH_B-1:0] pb_out,
  output logic [WIDTH_B-1:0] pb_oe,
  input  logic [WIDTH_C-1:0] pc_in,
  output logic [WIDTH_C-1:0] pc_out,
  output logic [WIDTH_C-1:0] pc_oe,
  output logic               dav,
  input  logic               ack,
  output logic               irq
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_HI = 2'd1,
    ST_WAIT_LO = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [WIDTH_A-1:0] pa_q, ddra_q;
  logic [WIDTH_B-1:0] pb_q, ddrb_q;
  logic [WIDTH_C-1:0] pc_q, ddrc_q;
  logic       hs_en_q, irq_en_q, done_q, ovr_q, dav_q, dav_d;
  logic       ack_s1_q, ack_s_q;
  logic [7:0] dout_q;

  logic w_wr, w_rd, w_wr_pa, w_wr_cr, w_rd_sr, w_busy, w_abort;
  logic w_pa_load, w_set_done, w_set_ovr, w_cnt_hit, w_tmo;
  logic [WIDTH_A-1:0] w_pa_view;
  logic [WIDTH_B-1:0] w_pb_view;
  logic [WIDTH_C-1:0] w_pc_view;
  logic [7:0] w_rd_data;

  assign w_wr    = cs & we;
  assign w_rd    = cs & ~we;
  assign w_wr_pa = w_wr && (rs == 3'd0);
  assign w_wr_cr = w_wr && (rs == 3'd6);
  assign w_rd_sr = w_rd && (rs == 3'd7);
  assign w_busy  = (state_q != ST_IDLE);
  assign w_abort = w_busy & w_wr_cr & ~din[0];

  assign w_pa_view = (pa_in & ~ddra_q) | (pa_q & ddra_q);
  assign w_pb_view = (pb_in & ~ddrb_q) | (pb_q & ddrb_q);
  assign w_pc_view = (pc_in & ~ddrc_q) | (pc_q & ddrc_q);

`ifdef TPI_HS_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        tmo_q;

  assign w_cnt_hit = w_busy && ((cnt_q + 16'd1) == 16'(TIMEOUT));
  assign w_tmo     = tmo_q;

  // Counter restarts on every state change and idles at zero.
  always_comb begin
    cnt_d = '0;
    if (w_busy && (state_d == state_q)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= (tmo_q & ~w_rd_sr) | (w_cnt_hit & ~w_abort);
    end
  end
`else
  assign w_cnt_hit = 1'b0;
  assign w_tmo     = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    dav_d      = dav_q;
    w_set_done = 1'b0;
    w_set_ovr  = w_wr_pa & w_busy;
    w_pa_load  = w_wr_pa & ~w_busy;
    case (state_q)
      ST_IDLE: begin
        if (w_wr_pa && hs_en_q) begin
          state_d = ST_WAIT_HI;
          dav_d   = 1'b1;
        end
      end
      ST_WAIT_HI: begin
        if (ack_s_q) begin
          state_d = ST_WAIT_LO;
          dav_d   = 1'b0;
        end
      end
      ST_WAIT_LO: begin
        if (!ack_s_q) begin
          state_d    = ST_IDLE;
          w_set_done = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        dav_d   = 1'b0;
      end
    endcase
    // Abort and timeout both end the handshake without reporting completion.
    if (w_abort || w_cnt_hit) begin
      state_d    = ST_IDLE;
      dav_d      = 1'b0;
      w_set_done = 1'b0;
    end
  end

  always_comb begin
    w_rd_data = 8'h00;
    case (rs)
      3'd0: w_rd_data = 8'(w_pa_view);
      3'd1: w_rd_data = 8'(w_pb_view);
      3'd2: w_rd_data = 8'(w_pc_view) << (8 - WIDTH_C);
      3'd3: w_rd_data = 8'(ddra_q);
      3'd4: w_rd_data = 8'(ddrb_q);
      3'd5: w_rd_data = 8'(ddrc_q) << (8 - WIDTH_C);
      3'd6: w_rd_data = {6'b0, irq_en_q, hs_en_q};
      3'd7: w_rd_data = {4'b0, ovr_q, w_tmo, done_q, w_busy};
      default: w_rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      dav_q    <= 1'b0;
      ack_s1_q <= 1'b0;
      ack_s_q  <= 1'b0;
      pa_q     <= '0;
      pb_q     <= '0;
      pc_q     <= '0;
      ddra_q   <= '0;
      ddrb_q   <= '0;
      ddrc_q   <= '0;
      hs_en_q  <= 1'b0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      dout_q   <= 8'h00;
    end else begin
      ack_s1_q <= ack;
      ack_s_q  <= ack_s1_q;
      state_q  <= state_d;
      dav_q    <= dav_d;
      if (w_pa_load)                  pa_q   <= din[WIDTH_A-1:0];
      if (w_wr && rs == 3'd1)         pb_q   <= din[WIDTH_B-1:0];
      if (w_wr && rs == 3'd2)         pc_q   <= din[7 -: WIDTH_C];
      if (w_wr && rs == 3'd3)         ddra_q <= din[WIDTH_A-1:0];
      if (w_wr && rs == 3'd4)         ddrb_q <= din[WIDTH_B-1:0];
      if (w_wr && rs == 3'd5)         ddrc_q <= din[7 -: WIDTH_C];
      if (w_wr_cr) {irq_en_q, hs_en_q} <= din[1:0];
      // A flag set in the same cycle as an SR read survives the clear.
      done_q <= (done_q & ~w_rd_sr) | w_set_done;
      ovr_q  <= (ovr_q & ~w_rd_sr) | w_set_ovr;
      if (w_rd) dout_q <= w_rd_data;
    end
  end

  assign dout   = dout_q;
  assign pa_out = pa_q;
  assign pa_oe  = ddra_q;
  assign pb_out = pb_q;
  assign pb_oe  = ddrb_q;
  assign pc_out = pc_q;
  assign pc_oe  = ddrc_q;
  assign dav    = dav_q;
  assign irq    = irq_en_q & (done_q | w_tmo);

endmodule
`default_nettype wire

// File: tb/tb_tpi_hs.sv
`default_nettype none
// ============================================================================
// Module   : tb_tpi_hs
// Brief    : Directed self-checking bench for tpi_hs with a read scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tpi_hs;

  logic       clock = 1'b0;
  logic       reset, cs, we, ack;
  logic [2:0] rs;
  logic [7:0] din, dout;
  logic [7:0] pa_in, pa_out, pa_oe;
  logic [1:0] pb_in, pb_out, pb_oe;
  logic [1:0] pc_in, pc_out, pc_oe;
  logic       dav, irq;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clock = ~clock;

  tpi_hs #(.WIDTH_A(8), .WIDTH_B(2), .WIDTH_C(2), .TIMEOUT(16)) dut (
    .clock(clock), .reset(reset), .cs(cs), .we(we), .rs(rs), .din(din),
    .dout(dout),
    .pa_in(pa_in), .pa_out(pa_out), .pa_oe(pa_oe),
    .pb_in(pb_in), .pb_out(pb_out), .pb_oe(pb_oe),
    .pc_in(pc_in), .pc_out(pc_out), .pc_oe(pc_oe),
    .dav(dav), .ack(ack), .irq(irq)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; rs = a; din = d;
    tick();
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [7:0] expv);
    logic [7:0] e;
    exp_q.push_back(expv);
    cs = 1'b1; we = 1'b0; rs = a;
    tick();
    cs = 1'b0;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, dout);
    end else begin
      e = exp_q.pop_front();
      chk(tag, dout, e);
    end
  endtask

  initial begin
    reset = 1'b1; cs = 1'b0; we = 1'b0; rs = 3'd0; din = 8'h00; ack = 1'b0;
    pa_in = 8'h00; pb_in = 2'b00; pc_in = 2'b00;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    chk("rst_dout", dout, 8'h00);
    chk("rst_dav", {7'b0, dav}, 8'h00);
    chk("rst_irq", {7'b0, irq}, 8'h00);
    chk("rst_oe", {pa_oe | {6'b0, pb_oe} | {6'b0, pc_oe}}, 8'h00);
    for (int i = 0; i < 8; i++) rd($sformatf("rst_reg%0d", i), 3'(i), 8'h00);

    // Port A mixed direction
    pa_in = 8'h3C;
    wr(3'd3, 8'hF0);
    wr(3'd0, 8'hA5);
    chk("pa_out", pa_out, 8'hA5);
    chk("pa_oe", pa_oe, 8'hF0);
    rd("pa_read", 3'd0, 8'hAC);

    // Narrow ports: B LSB-aligned, C MSB-aligned
    wr(3'd4, 8'hFF); wr(3'd1, 8'hFF); wr(3'd5, 8'hFF); wr(3'd2, 8'hFF);
    chk("pb_oe", {6'b0, pb_oe}, 8'h03);
    chk("pc_oe", {6'b0, pc_oe}, 8'h03);
    rd("pb_read", 3'd1, 8'h03);
    rd("pc_read", 3'd2, 8'hC0);
    rd("ddrc_read", 3'd5, 8'hC0);

    // Full handshake
    wr(3'd6, 8'h03);
    rd("cr_read", 3'd6, 8'h03);
    wr(3'd0, 8'h55);
    chk("hs_dav_rise", {7'b0, dav}, 8'h01);
    chk("hs_pa_out", pa_out, 8'h55);
    rd("hs_sr_busy", 3'd7, 8'h01);
    ack = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("hs_dav_c%0d", i), {7'b0, dav}, (i < 3) ? 8'h01 : 8'h00);
    end
    ack = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("hs_irq_c%0d", i), {7'b0, irq}, (i < 3) ? 8'h00 : 8'h01);
    end
    rd("hs_sr_done", 3'd7, 8'h02);
    rd("hs_sr_clr", 3'd7, 8'h00);
    chk("hs_irq_clr", {7'b0, irq}, 8'h00);

    // Overrun, then SR read colliding with done
    wr(3'd0, 8'h55);
    wr(3'd0, 8'h77);
    chk("ovr_pa_hold", pa_out, 8'h55);
    rd("ovr_sr", 3'd7, 8'h09);
    ack = 1'b1;
    repeat (3) tick();
    chk("ovr_dav_low", {7'b0, dav}, 8'h00);
    ack = 1'b0;
    repeat (2) tick();
    rd("race_sr_first", 3'd7, 8'h01);
    chk("race_irq", {7'b0, irq}, 8'h01);
    rd("race_sr_second", 3'd7, 8'h02);
    chk("race_irq_clr", {7'b0, irq}, 8'h00);

    // Plain latch write with handshake disabled
    wr(3'd6, 8'h02);
    wr(3'd0, 8'h12);
    chk("plain_pa", pa_out, 8'h12);
    chk("plain_dav", {7'b0, dav}, 8'h00);
    rd("plain_sr", 3'd7, 8'h00);

    // Abort by clearing hs_en
    wr(3'd6, 8'h03);
    wr(3'd0, 8'h34);
    chk("abort_dav_rise", {7'b0, dav}, 8'h01);
    wr(3'd6, 8'h02);
    chk("abort_dav", {7'b0, dav}, 8'h00);
    rd("abort_sr", 3'd7, 8'h00);
    chk("abort_irq", {7'b0, irq}, 8'h00);

`ifdef TPI_HS_TIMEOUT_EN
    wr(3'd6, 8'h03);
    wr(3'd0, 8'h66);
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk($sformatf("tmo_dav_c%0d", i), {7'b0, dav}, (i < 16) ? 8'h01 : 8'h00);
    end
    chk("tmo_irq", {7'b0, irq}, 8'h01);
    rd("tmo_sr", 3'd7, 8'h04);
    chk("tmo_irq_clr", {7'b0, irq}, 8'h00);
`endif

    // Reset mid-handshake
    wr(3'd6, 8'h03);
    wr(3'd0, 8'h21);
    chk("mid_rst_dav_rise", {7'b0, dav}, 8'h01);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_dav", {7'b0, dav}, 8'h00);
    chk("mid_rst_pa", pa_out, 8'h00);
    rd("mid_rst_sr", 3'd7, 8'h00);
    rd("mid_rst_cr", 3'd6, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
